mips_multicycle_ctrl: RTL and testbench

Multi-cycle control unit for the next-generation MIPS core. It replaces the single-cycle combinational control path with a registered FSM, which lets one ALU and one unified memory be shared across fetch, execute and data access. It adds a memory ready handshake so that variable-latency memory stalls the core cleanly. It sits between the instruction register (opcode and funct inputs) and the shared datapath muxes and enables.

---
 rtl/mips_pkg.sv | 64 ++++++
 rtl/mips_mem_wait_timer.sv | 36 +++
 rtl/mips_multicycle_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants, state encoding and decode helpers for the multi-cycle MIPS control path.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_RTYPE = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_LUI   = 3'd5;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13
    } state_e;

    // Unknown opcodes map to S_FETCH; no legal opcode decodes there.
    function automatic state_e decode_next(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE:                       return (fn == FUNCT_JR) ? S_JR : S_EXEC_R;
            OP_LW, OP_SW:                   return S_MEM_ADDR;
            OP_BEQ, OP_BNE:                 return S_BRANCH;
            OP_J:                           return S_JUMP;
            OP_JAL:                         return S_JAL;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: return S_EXEC_I;
            default:                        return S_FETCH;
        endcase
    endfunction

    function automatic logic [2:0] alu_class_i(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_LUI:  return ALU_LUI;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Memory wait watchdog: counts stalled cycles, flags expiry on the LIMIT-th one.
// LIMIT = 0 never expires.
module mips_mem_wait_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired_o = (LIMIT != 0) && en_i && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expired_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM sharing one ALU and one memory, with mem_ready stalls and timeout.
// state      | meaning
// FETCH      | read instruction at PC, PC+4; waits on mem_ready
// DECODE     | branch target into ALUOut, dispatch on opcode
// EXEC_R/I   | ALU operation for R-type / immediate ALU ops
// WB_R/I     | register write-back of ALUOut
// MEM_ADDR   | effective address for lw/sw
// MEM_RD/WR  | data access at ALUOut; waits on mem_ready
// WB_MEM     | register write-back of MDR
// BRANCH     | compare rs/rt, conditional PC load
// JUMP/JAL/JR| unconditional PC load (JAL also links)
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int          OP_W        = 6,
    parameter int          FUNCT_W     = 6,
    parameter int          ALUOP_W     = 3,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic [1:0]         RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               WBSel,
    output logic               illegal_op,
    output logic               bus_err,
    output logic [3:0]         state_dbg
);
    state_e     state_q, state_d;
    logic [5:0] op, fn;
    logic       wait_en, tmo;

    assign op        = 6'(opcode);
    assign fn        = 6'(funct);
    assign state_dbg = state_q;
    assign wait_en   = (state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR}) && !mem_ready;

    mips_mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (reset),
        .clr_i     ((state_d != state_q) || tmo),
        .en_i      (wait_en),
        .expired_o (tmo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE:   state_d = decode_next(op, fn);
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_ADDR: state_d = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)   state_d = S_WB_MEM;
                else if (tmo)    state_d = S_FETCH;
            end
            S_MEM_WR:   if (mem_ready || tmo) state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Everything is forced low while reset is held so no partial write commits.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 2'd0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        PCSource    = 2'd0;
        ALUOp       = ALUOP_W'(ALU_ADD);
        WBSel       = 1'b0;
        illegal_op  = 1'b0;
        bus_err     = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'd1;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                    bus_err = tmo;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'd3;
                    illegal_op = (decode_next(op, fn) == S_FETCH);
                end
                S_EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_W'(ALU_RTYPE);
                end
                S_WB_R: begin
                    RegDst   = 2'd1;
                    RegWrite = 1'b1;
                end
                S_EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                    ALUOp   = ALUOP_W'(alu_class_i(op));
                end
                S_WB_I:     RegWrite = 1'b1;
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                end
                S_MEM_RD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                    bus_err = tmo;
                end
                S_WB_MEM: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEM_WR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                    bus_err  = tmo;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_W'(ALU_SUB);
                    PCSource    = 2'd1;
                    PCWriteCond = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
                end
                S_JUMP: begin
                    PCSource = 2'd2;
                    PCWrite  = 1'b1;
                end
                S_JAL: begin
                    PCSource = 2'd2;
                    PCWrite  = 1'b1;
                    RegDst   = 2'd2;
                    WBSel    = 1'b1;
                    RegWrite = 1'b1;
                end
                S_JR: begin
                    PCSource = 2'd3;
                    PCWrite  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle vector table plus timeout and async-reset sequences.
module tb_mips_multicycle_ctrl;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
    logic [1:0] RegDst, ALUSrcB, PCSource;
    logic       RegWrite, ALUSrcA, WBSel, illegal_op, bus_err;
    logic [2:0] ALUOp;
    logic [3:0] state_dbg;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(
        .OP_W(6), .FUNCT_W(6), .ALUOP_W(3), .MEM_TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALUOp(ALUOp), .WBSel(WBSel), .illegal_op(illegal_op),
        .bus_err(bus_err), .state_dbg(state_dbg)
    );

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r;
        logic [1:0] regdst;
        logic       rw, srca;
        logic [1:0] srcb, pcsrc;
        logic [2:0] aluop;
        logic       wbsel, ill, berr;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        state_e     st;
        ctl_t       ctl;
    } vec_t;

    typedef struct {
        state_e st;
        ctl_t   ctl;
        string  name;
    } exp_t;

    localparam ctl_t C_ZERO     = '0;
    localparam ctl_t C_FWAIT    = '{mrd: 1'b1, srcb: 2'd1, aluop: ALU_ADD, default: '0};
    localparam ctl_t C_FWAIT_E  = '{mrd: 1'b1, srcb: 2'd1, aluop: ALU_ADD, berr: 1'b1, default: '0};
    localparam ctl_t C_FGO      = '{pcw: 1'b1, irw: 1'b1, mrd: 1'b1, srcb: 2'd1, aluop: ALU_ADD, default: '0};
    localparam ctl_t C_DEC      = '{srcb: 2'd3, aluop: ALU_ADD, default: '0};
    localparam ctl_t C_DEC_ILL  = '{srcb: 2'd3, aluop: ALU_ADD, ill: 1'b1, default: '0};
    localparam ctl_t C_EXR      = '{srca: 1'b1, srcb: 2'd0, aluop: ALU_RTYPE, default: '0};
    localparam ctl_t C_WBR      = '{regdst: 2'd1, rw: 1'b1, default: '0};
    localparam ctl_t C_EXI_ADD  = '{srca: 1'b1, srcb: 2'd2, aluop: ALU_ADD, default: '0};
    localparam ctl_t C_EXI_AND  = '{srca: 1'b1, srcb: 2'd2, aluop: ALU_AND, default: '0};
    localparam ctl_t C_EXI_OR   = '{srca: 1'b1, srcb: 2'd2, aluop: ALU_OR, default: '0};
    localparam ctl_t C_EXI_LUI  = '{srca: 1'b1, srcb: 2'd2, aluop: ALU_LUI, default: '0};
    localparam ctl_t C_WBI      = '{regdst: 2'd0, rw: 1'b1, default: '0};
    localparam ctl_t C_MADDR    = '{srca: 1'b1, srcb: 2'd2, aluop: ALU_ADD, default: '0};
    localparam ctl_t C_MRD      = '{iord: 1'b1, mrd: 1'b1, default: '0};
    localparam ctl_t C_WBMEM    = '{m2r: 1'b1, rw: 1'b1, default: '0};
    localparam ctl_t C_MWR      = '{iord: 1'b1, mwr: 1'b1, default: '0};
    localparam ctl_t C_MWR_E    = '{iord: 1'b1, mwr: 1'b1, berr: 1'b1, default: '0};
    localparam ctl_t C_BR_T     = '{srca: 1'b1, srcb: 2'd0, aluop: ALU_SUB, pcsrc: 2'd1, pcwc: 1'b1, default: '0};
    localparam ctl_t C_BR_N     = '{srca: 1'b1, srcb: 2'd0, aluop: ALU_SUB, pcsrc: 2'd1, default: '0};
    localparam ctl_t C_JUMP     = '{pcsrc: 2'd2, pcw: 1'b1, default: '0};
    localparam ctl_t C_JAL      = '{pcsrc: 2'd2, pcw: 1'b1, regdst: 2'd2, wbsel: 1'b1, rw: 1'b1, default: '0};
    localparam ctl_t C_JR       = '{pcsrc: 2'd3, pcw: 1'b1, default: '0};

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] OP_BAD = 6'h3F;

    ctl_t act;
    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                  RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, WBSel, illegal_op, bus_err};

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    vec_t tbl[$];

    task automatic compare(input string name, input state_e est, input ctl_t ectl);
        n_vec++;
        if (state_dbg !== est || act !== ectl) begin
            n_err++;
            $display("FAIL %s: got state=%0d ctl=%06h, expected state=%0d ctl=%06h",
                     name, state_dbg, act, est, ectl);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare(e.name, e.st, e.ctl);
        end
    end

    function automatic vec_t row(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                 input logic rdy, input state_e st, input ctl_t c);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.st = st; v.ctl = c;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        exp_t e;
        opcode = v.op; funct = v.fn; zero = v.z; mem_ready = v.rdy;
        e.st = v.st; e.ctl = v.ctl; e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy,
                        input state_e st, input ctl_t c, input string name);
        apply(row(op, fn, z, rdy, st, c), name);
    endtask

    // Fetch (ready at once) and decode rows shared by most table entries.
    task automatic pre(input logic [5:0] op, input logic [5:0] fn, input logic z);
        tbl.push_back(row(op, fn, z, 1'b1, S_FETCH, C_FGO));
        tbl.push_back(row(op, fn, z, 1'b1, S_DECODE, C_DEC));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion before 100000");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; opcode = OP_RTYPE; funct = F_ADD; zero = 1'b0; mem_ready = 1'b1;

        pre(OP_RTYPE, F_ADD, 1'b0);
        tbl.push_back(row(OP_RTYPE, F_ADD, 1'b0, 1'b1, S_EXEC_R, C_EXR));
        tbl.push_back(row(OP_RTYPE, F_ADD, 1'b0, 1'b1, S_WB_R, C_WBR));
        pre(OP_LW, 6'h00, 1'b0);
        tbl.push_back(row(OP_LW, 6'h00, 1'b0, 1'b1, S_MEM_ADDR, C_MADDR));
        tbl.push_back(row(OP_LW, 6'h00, 1'b0, 1'b0, S_MEM_RD, C_MRD));
        tbl.push_back(row(OP_LW, 6'h00, 1'b0, 1'b0, S_MEM_RD, C_MRD));
        tbl.push_back(row(OP_LW, 6'h00, 1'b0, 1'b1, S_MEM_RD, C_MRD));
        tbl.push_back(row(OP_LW, 6'h00, 1'b0, 1'b1, S_WB_MEM, C_WBMEM));
        pre(OP_SW, 6'h00, 1'b0);
        tbl.push_back(row(OP_SW, 6'h00, 1'b0, 1'b1, S_MEM_ADDR, C_MADDR));
        tbl.push_back(row(OP_SW, 6'h00, 1'b0, 1'b1, S_MEM_WR, C_MWR));
        pre(OP_BEQ, 6'h00, 1'b1);
        tbl.push_back(row(OP_BEQ, 6'h00, 1'b1, 1'b1, S_BRANCH, C_BR_T));
        pre(OP_BNE, 6'h00, 1'b1);
        tbl.push_back(row(OP_BNE, 6'h00, 1'b1, 1'b1, S_BRANCH, C_BR_N));
        pre(OP_BNE, 6'h00, 1'b0);
        tbl.push_back(row(OP_BNE, 6'h00, 1'b0, 1'b1, S_BRANCH, C_BR_T));
        pre(OP_BEQ, 6'h00, 1'b0);
        tbl.push_back(row(OP_BEQ, 6'h00, 1'b0, 1'b1, S_BRANCH, C_BR_N));
        pre(OP_ADDI, 6'h00, 1'b0);
        tbl.push_back(row(OP_ADDI, 6'h00, 1'b0, 1'b1, S_EXEC_I, C_EXI_ADD));
        tbl.push_back(row(OP_ADDI, 6'h00, 1'b0, 1'b1, S_WB_I, C_WBI));
        pre(OP_ANDI, 6'h00, 1'b0);
        tbl.push_back(row(OP_ANDI, 6'h00, 1'b0, 1'b1, S_EXEC_I, C_EXI_AND));
        tbl.push_back(row(OP_ANDI, 6'h00, 1'b0, 1'b1, S_WB_I, C_WBI));
        pre(OP_ORI, 6'h00, 1'b0);
        tbl.push_back(row(OP_ORI, 6'h00, 1'b0, 1'b1, S_EXEC_I, C_EXI_OR));
        tbl.push_back(row(OP_ORI, 6'h00, 1'b0, 1'b1, S_WB_I, C_WBI));
        tbl.push_back(row(OP_LUI, 6'h00, 1'b0, 1'b0, S_FETCH, C_FWAIT));
        pre(OP_LUI, 6'h00, 1'b0);
        tbl.push_back(row(OP_LUI, 6'h00, 1'b0, 1'b1, S_EXEC_I, C_EXI_LUI));
        tbl.push_back(row(OP_LUI, 6'h00, 1'b0, 1'b1, S_WB_I, C_WBI));
        pre(OP_J, 6'h00, 1'b0);
        tbl.push_back(row(OP_J, 6'h00, 1'b0, 1'b1, S_JUMP, C_JUMP));
        pre(OP_JAL, 6'h00, 1'b0);
        tbl.push_back(row(OP_JAL, 6'h00, 1'b0, 1'b1, S_JAL, C_JAL));
        pre(OP_RTYPE, FUNCT_JR, 1'b0);
        tbl.push_back(row(OP_RTYPE, FUNCT_JR, 1'b0, 1'b1, S_JR, C_JR));
        tbl.push_back(row(OP_BAD, 6'h00, 1'b0, 1'b1, S_FETCH, C_FGO));
        tbl.push_back(row(OP_BAD, 6'h00, 1'b0, 1'b1, S_DECODE, C_DEC_ILL));
        tbl.push_back(row(OP_RTYPE, F_ADD, 1'b0, 1'b0, S_FETCH, C_FWAIT));

        // Outputs must all be low while reset is held.
        #1;
        begin
            exp_t e;
            e.st = S_FETCH; e.ctl = C_ZERO; e.name = "reset_state";
            exp_q.push_back(e);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        // sw with mem_ready never arriving: bus_err on the 15th MEM_WR cycle, back to FETCH.
        step(OP_SW, 6'h00, 1'b0, 1'b1, S_FETCH, C_FGO, "swt_fetch");
        step(OP_SW, 6'h00, 1'b0, 1'b1, S_DECODE, C_DEC, "swt_dec");
        step(OP_SW, 6'h00, 1'b0, 1'b1, S_MEM_ADDR, C_MADDR, "swt_addr");
        for (int k = 1; k < 15; k++) begin
            step(OP_SW, 6'h00, 1'b0, 1'b0, S_MEM_WR, C_MWR, $sformatf("swt_wait%0d", k));
        end
        step(OP_SW, 6'h00, 1'b0, 1'b0, S_MEM_WR, C_MWR_E, "swt_buserr");
        step(OP_SW, 6'h00, 1'b0, 1'b0, S_FETCH, C_FWAIT, "swt_refetch");
        step(OP_SW, 6'h00, 1'b0, 1'b1, S_FETCH, C_FGO, "swr_fetch");

        // Same sw, but ready arrives in the expiry cycle: completion wins.
        step(OP_SW, 6'h00, 1'b0, 1'b1, S_DECODE, C_DEC, "swr_dec");
        step(OP_SW, 6'h00, 1'b0, 1'b1, S_MEM_ADDR, C_MADDR, "swr_addr");
        for (int k = 1; k < 15; k++) begin
            step(OP_SW, 6'h00, 1'b0, 1'b0, S_MEM_WR, C_MWR, $sformatf("swr_wait%0d", k));
        end
        step(OP_SW, 6'h00, 1'b0, 1'b1, S_MEM_WR, C_MWR, "swr_ready15");
        step(OP_J, 6'h00, 1'b0, 1'b1, S_FETCH, C_FGO, "ft_fetch_j");

        // Fetch timeout: stays in FETCH with bus_err, no IRWrite/PCWrite.
        step(OP_J, 6'h00, 1'b0, 1'b1, S_DECODE, C_DEC, "ft_dec_j");
        step(OP_J, 6'h00, 1'b0, 1'b1, S_JUMP, C_JUMP, "ft_jump");
        for (int k = 1; k < 15; k++) begin
            step(OP_RTYPE, F_ADD, 1'b0, 1'b0, S_FETCH, C_FWAIT, $sformatf("ft_wait%0d", k));
        end
        step(OP_RTYPE, F_ADD, 1'b0, 1'b0, S_FETCH, C_FWAIT_E, "ft_buserr");
        step(OP_RTYPE, F_ADD, 1'b0, 1'b1, S_FETCH, C_FGO, "ft_refetch");
        step(OP_RTYPE, F_ADD, 1'b0, 1'b1, S_DECODE, C_DEC, "rst_dec");
        step(OP_RTYPE, F_ADD, 1'b0, 1'b1, S_EXEC_R, C_EXR, "rst_exec");

        // Reset asserted in WB_R: RegWrite must drop without waiting for a clock.
        #2;
        compare("rst_wbr_before", S_WB_R, C_WBR);
        reset = 1'b0;
        #1;
        compare("rst_async_drop", S_FETCH, C_ZERO);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(OP_RTYPE, F_ADD, 1'b0, 1'b1, S_FETCH, C_FGO, "rst_after_fetch");
        step(OP_RTYPE, F_ADD, 1'b0, 1'b1, S_DECODE, C_DEC, "rst_after_dec");

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
